core_mem_responder: RTL and testbench
=====================================

Name: core_mem_responder

Overview:
Memory-side responder for the core's two-port memory interface. Port 1 serves instruction fetch (read-only); port 2 serves data access (read plus byte-enabled write). The block holds a word-organised RAM and a program-load port. A small FSM keeps the core in reset while the program loads, then releases it. On an out-of-range access the FSM faults, re-asserts core reset and latches the offending address.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM; power of two, at least 4.
IDX_W, $clog2(DEPTH_WORDS), word-index width; derived, not to be overridden.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mem_addr1  in  32  port-1 byte address (fetch)
mem_rd_data1  out  32  port-1 read data
mem_addr2  in  32  port-2 byte address (data)
mem_rd_data2  out  32  port-2 read data
mem_wr_en  in  1  port-2 write strobe
mem_wr_data  in  32  port-2 write data, lane-aligned
mem_byte_en  in  4  port-2 byte enables; bit i controls byte i
ld_valid  in  1  load word valid
ld_ready  out  1  load word accepted
ld_data  in  32  load word
ld_last  in  1  final load word
core_rst_n  out  1  active-low reset to the core
fault  out  1  sticky out-of-range fault
fault_addr  out  32  byte address that caused the first fault
words_loaded  out  IDX_W+1  count of words accepted on the load port

Behaviour:
- FSM states: LOAD (reset state), RUN, FAULT. State register uses the asynchronous reset.
- Reset values: state=LOAD, core_rst_n=0, fault=0, fault_addr=0, words_loaded=0. RAM contents are not reset.
- ld_ready = (state==LOAD); this is purely combinational from state.
- Outputs core_rst_n, fault and fault_addr come from flops updated at the same edge as state. core_rst_n=1 only while in RUN.
- Addressing:
  - Word index = addr[IDX_W+1:2]. addr[1:0] are ignored.
  - An address is in range iff addr[31:IDX_W+2]==0.
- Reads (both ports) are combinational, with zero cycles of latency; the core consumes fetch data in the same cycle.
  - In-range read returns RAM[index].
  - Out-of-range read returns 32'h0.
  - Reads are functional in every state.
- Read during write: a port-2 write becomes visible to both ports only after the clock edge. A same-cycle read returns the old contents.
- LOAD:
  - Each cycle with ld_valid=1 writes ld_data to RAM[words_loaded[IDX_W-1:0]] and increments words_loaded.
  - The FSM goes to RUN on an accepted word with ld_last=1, or on the accepted word written at index DEPTH_WORDS-1, whichever comes first.
  - Port-2 writes are ignored in LOAD.
  - No fault checking in LOAD.
- RUN:
  - Write: if mem_wr_en=1 and addr2 is in range, each byte i with mem_byte_en[i]=1 is written from mem_wr_data[8i+7:8i]. mem_byte_en=0 means no write.
  - Fault condition: addr1 out of range, or addr2 out of range while mem_wr_en=1. Data-port reads out of range do not fault, because the core drives addr2 every cycle.
  - On a fault:
    - the write is suppressed;
    - fault<=1;
    - fault_addr<=addr1 if port 1 faulted, else addr2 (port 1 has priority on simultaneous faults);
    - state<=FAULT, which drops core_rst_n at the same edge.
- FAULT:
  - Terminal state. core_rst_n=0 and fault=1 hold, and no writes occur.
  - Ld inputs are ignored; ld_ready=0.
  - The only exit is rst_n.
- ld_valid after RUN is entered: ignored, ld_ready=0, words_loaded frozen.
- rst_n asserted mid-load or mid-run:
  - FSM, counters and flags return to reset values immediately.
  - An in-flight write at that edge is dropped.
  - RAM contents are retained but are treated as undefined.

Test Plan:
- Load 4 words (0x00000093, 0x00100113, 0x002081B3, 0x0000006F) with ld_last on the 4th → ld_ready=0 the next cycle, core_rst_n=1, words_loaded=4; mem_addr1=0x8 reads 0x002081B3.
- In RUN, write 0xAABBCCDD to 0x10 with byte_en=4'b1111, then 0x11223344 to 0x10 with byte_en=4'b0010 → mem_rd_data2 at 0x10 reads 0xAABB33DD. The same-cycle read during the second write returns 0xAABBCCDD.
- With DEPTH_WORDS=1024 in RUN, set mem_addr1=0x00001000 → mem_rd_data1=0, and at the next edge fault=1, fault_addr=0x00001000, core_rst_n=0. A later write to 0x0 leaves RAM[0] unchanged.
- Simultaneous fault: addr1=0x2000, addr2=0x3000 with mem_wr_en=1 → fault_addr=0x2000 and no write occurs.
- Load with ld_last never asserted: 1024 valid words → RUN entered after word 1024, words_loaded=1024, and further ld_valid is ignored.
- Assert rst_n low after 2 load words → words_loaded=0, state LOAD, ld_ready=1, core_rst_n=0 immediately (asynchronously). Reloading 1 word with ld_last → RUN.

Source files
------------

// File: rtl/core_mem_responder.sv
// Memory-side responder for the core's fetch/data ports: word RAM, program-load
// port and a LOAD/RUN/FAULT sequencer that holds the core in reset.
module core_mem_responder #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      mem_addr1,
    output logic [31:0]      mem_rd_data1,
    input  logic [31:0]      mem_addr2,
    output logic [31:0]      mem_rd_data2,
    input  logic             mem_wr_en,
    input  logic [31:0]      mem_wr_data,
    input  logic [3:0]       mem_byte_en,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_data,
    input  logic             ld_last,
    output logic             core_rst_n,
    output logic             fault,
    output logic [31:0]      fault_addr,
    output logic [IDX_W:0]   words_loaded
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t             r_state;
    logic               r_core_rst_n;
    logic               r_fault;
    logic [31:0]        r_fault_addr;
    logic [IDX_W:0]     r_words_loaded;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic [IDX_W-1:0]   w_idx1;
    logic [IDX_W-1:0]   w_idx2;
    logic [IDX_W-1:0]   w_ld_idx;
    logic               w_oor1;
    logic               w_oor2;
    logic               w_fault;
    logic               w_ld_we;
    logic               w_wr_we;
    logic               w_ld_full;
    logic               w_unused_lsbs;

    assign w_idx1   = mem_addr1[IDX_W+1:2];
    assign w_idx2   = mem_addr2[IDX_W+1:2];
    assign w_ld_idx = r_words_loaded[IDX_W-1:0];
    assign w_oor1   = |mem_addr1[31:IDX_W+2];
    assign w_oor2   = |mem_addr2[31:IDX_W+2];
    assign w_unused_lsbs = ^{mem_addr1[1:0], mem_addr2[1:0]};

    // Data-port reads out of range are harmless; only fetches and writes fault.
    assign w_fault   = w_oor1 | (mem_wr_en & w_oor2);
    assign w_ld_full = (w_ld_idx == IDX_W'(DEPTH_WORDS - 1));

    // rst_n gates the strobes so a write coinciding with reset is dropped.
    assign w_ld_we = rst_n && (r_state == ST_LOAD) && ld_valid;
    assign w_wr_we = rst_n && (r_state == ST_RUN) && mem_wr_en && !w_fault;

    assign mem_rd_data1 = w_oor1 ? '0 : r_mem[w_idx1];
    assign mem_rd_data2 = w_oor2 ? '0 : r_mem[w_idx2];

    assign ld_ready     = (r_state == ST_LOAD);
    assign core_rst_n   = r_core_rst_n;
    assign fault        = r_fault;
    assign fault_addr   = r_fault_addr;
    assign words_loaded = r_words_loaded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_LOAD;
            r_core_rst_n   <= 1'b0;
            r_fault        <= 1'b0;
            r_fault_addr   <= '0;
            r_words_loaded <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (ld_valid) begin
                        r_words_loaded <= r_words_loaded + {{IDX_W{1'b0}}, 1'b1};
                        if (ld_last || w_ld_full) begin
                            r_state      <= ST_RUN;
                            r_core_rst_n <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_fault) begin
                        r_state      <= ST_FAULT;
                        r_core_rst_n <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_addr <= w_oor1 ? mem_addr1 : mem_addr2;
                    end
                end
                ST_FAULT: begin
                    r_core_rst_n <= 1'b0;
                end
                default: begin
                    r_state      <= ST_FAULT;
                    r_core_rst_n <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld_we) begin
            r_mem[w_ld_idx] <= ld_data;
        end else if (w_wr_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_byte_en[i]) begin
                    r_mem[w_idx2][8*i +: 8] <= mem_wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_core_mem_responder.sv
// Randomized self-checking bench for core_mem_responder against a
// transaction-level model of the load/run/fault behaviour.
module tb_core_mem_responder;

    localparam int DEPTH = 1024;
    localparam int IW    = $clog2(DEPTH);
    localparam int M_LOAD = 0, M_RUN = 1, M_FAULT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   mem_addr1 = '0, mem_addr2 = '0, mem_wr_data = '0, ld_data = '0;
    logic [31:0]   mem_rd_data1, mem_rd_data2, fault_addr;
    logic          mem_wr_en = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [3:0]    mem_byte_en = '0;
    logic          ld_ready, core_rst_n, fault;
    logic [IW:0]   words_loaded;

    always #5 clk = ~clk;

    core_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr1(mem_addr1), .mem_rd_data1(mem_rd_data1),
        .mem_addr2(mem_addr2), .mem_rd_data2(mem_rd_data2),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .core_rst_n(core_rst_n), .fault(fault), .fault_addr(fault_addr),
        .words_loaded(words_loaded)
    );

    // Reference model
    int          mstate;
    int unsigned mcount;
    logic [31:0] mmem [DEPTH];
    bit          mvalid [DEPTH];
    bit          mfault;
    logic [31:0] mfa;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    task automatic model_reset();
        mstate = M_LOAD; mcount = 0; mfault = 0; mfa = '0;
        for (int i = 0; i < DEPTH; i++) mvalid[i] = 0;
    endtask

    // Apply model effect of the currently driven inputs, then clock the DUT.
    task automatic step();
        int w;
        if (mstate == M_LOAD) begin
            if (ld_valid) begin
                mmem[mcount % DEPTH] = ld_data;
                mvalid[mcount % DEPTH] = 1;
                mcount++;
                if (ld_last || mcount == DEPTH) mstate = M_RUN;
            end
        end else if (mstate == M_RUN) begin
            if (!in_range(mem_addr1) || (mem_wr_en && !in_range(mem_addr2))) begin
                mfault = 1;
                mfa    = !in_range(mem_addr1) ? mem_addr1 : mem_addr2;
                mstate = M_FAULT;
            end else if (mem_wr_en) begin
                w = int'(mem_addr2 / 4);
                for (int b = 0; b < 4; b++)
                    if (mem_byte_en[b]) mmem[w][8*b +: 8] = mem_wr_data[8*b +: 8];
                if (mem_byte_en == 4'hF) mvalid[w] = 1;
                else if (mem_byte_en != 4'h0 && !mvalid[w]) mvalid[w] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".ld_ready"},   32'(ld_ready),   32'(mstate == M_LOAD));
        chk({tag, ".core_rst_n"}, 32'(core_rst_n), 32'(mstate == M_RUN));
        chk({tag, ".fault"},      32'(fault),      32'(mfault));
        chk({tag, ".fault_addr"}, fault_addr,      mfa);
        chk({tag, ".words"},      32'(words_loaded), mcount);
    endtask

    task automatic rd1(input string tag, input logic [31:0] a);
        int w;
        mem_addr1 = a;
        #1;
        if (!in_range(a)) chk(tag, mem_rd_data1, 32'h0);
        else begin
            w = int'(a / 4);
            if (mvalid[w]) chk(tag, mem_rd_data1, mmem[w]);
        end
        mem_addr1 = '0;
    endtask

    task automatic rd2(input string tag, input logic [31:0] a);
        int w;
        mem_addr2 = a;
        #1;
        if (!in_range(a)) chk(tag, mem_rd_data2, 32'h0);
        else begin
            w = int'(a / 4);
            if (mvalid[w]) chk(tag, mem_rd_data2, mmem[w]);
        end
        mem_addr2 = '0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_state(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        mem_addr2 = a; mem_wr_data = d; mem_byte_en = be; mem_wr_en = 1'b1;
        step();
        mem_wr_en = 1'b0; mem_byte_en = '0; mem_addr2 = '0;
    endtask

    logic [31:0] prog [4] = '{32'h00000093, 32'h00100113, 32'h002081B3, 32'h0000006F};

    initial begin
        logic [31:0] a, d, old;
        logic [3:0]  be;
        int          w;

        model_reset();
        #2;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Four-word program with ld_last on the final word
        for (int i = 0; i < 4; i++) load_word(prog[i], i == 3);
        check_state("load4");
        rd1("fetch_0x8", 32'h8);
        for (int i = 0; i < 4; i++) rd2("prog_rd2", 32'(i * 4));

        // Byte-lane merge and read-during-write
        wr(32'h10, 32'hAABBCCDD, 4'b1111);
        mem_addr2 = 32'h10; mem_wr_data = 32'h11223344; mem_byte_en = 4'b0010; mem_wr_en = 1'b1;
        #1;
        chk("rdw_old", mem_rd_data2, 32'hAABBCCDD);
        step();
        mem_wr_en = 1'b0; mem_byte_en = '0;
        chk("byte_merge", mem_rd_data2, 32'hAABB33DD);
        wr(32'h14, 32'h12345678, 4'b0000);

        // Prefill words 4..15, then random partial writes with same-cycle checks
        for (int i = 4; i < 16; i++) wr(32'(i * 4), $urandom, 4'hF);
        for (int n = 0; n < 40; n++) begin
            w  = $urandom_range(0, 15);
            a  = 32'(w * 4) | 32'($urandom_range(0, 3));
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            old = mmem[w];
            mem_addr2 = a; mem_wr_data = d; mem_byte_en = be; mem_wr_en = 1'b1;
            #1;
            chk("rand_rdw", mem_rd_data2, old);
            step();
            mem_wr_en = 1'b0;
            rd2("rand_rd2", a);
            rd1("rand_rd1", 32'(w * 4));
        end
        rd2("oor_rd2", 32'h4000);
        step();
        check_state("oor_rd2_nofault");

        // Fetch out of range
        mem_addr1 = 32'h00001000;
        #1;
        chk("oor_fetch_data", mem_rd_data1, 32'h0);
        step();
        mem_addr1 = '0;
        check_state("fetch_fault");
        wr(32'h0, 32'hFFFFFFFF, 4'hF);
        rd2("fault_nowrite", 32'h0);
        ld_valid = 1'b1; ld_data = $urandom;
        step();
        ld_valid = 1'b0;
        check_state("fault_hold");

        // Simultaneous fault: port 1 wins
        do_reset("rst2");
        load_word(32'h0BADF00D, 1'b1);
        mem_addr1 = 32'h2000; mem_addr2 = 32'h3000; mem_wr_en = 1'b1;
        mem_wr_data = 32'h55555555; mem_byte_en = 4'hF;
        step();
        mem_addr1 = '0; mem_addr2 = '0; mem_wr_en = 1'b0;
        check_state("dual_fault");
        rd2("dual_fault_ram0", 32'h0);

        // Data-port write fault
        do_reset("rst3");
        load_word($urandom, 1'b1);
        wr(32'h3000, $urandom, 4'hF);
        check_state("wr_fault");

        // Fetch fault suppresses an in-range write
        do_reset("rst4");
        load_word($urandom, 1'b0);
        load_word($urandom, 1'b1);
        mem_addr1 = 32'h1004;
        wr(32'h4, 32'hCAFEBABE, 4'hF);
        mem_addr1 = '0;
        check_state("fetch_fault_wr");
        rd2("suppressed_wr", 32'h4);

        // Full-depth load without ld_last, with port-2 writes that must be ignored
        do_reset("rst5");
        load_word($urandom, 1'b0);
        mem_addr2 = 32'h0; mem_wr_data = 32'hDEADBEEF; mem_byte_en = 4'hF; mem_wr_en = 1'b1;
        for (int i = 1; i < DEPTH - 1; i++) load_word($urandom, 1'b0);
        check_state("load1023");
        load_word($urandom, 1'b0);
        mem_wr_en = 1'b0; mem_addr2 = '0;
        check_state("load1024");
        ld_valid = 1'b1; ld_last = 1'b1; ld_data = $urandom;
        step(); step();
        ld_valid = 1'b0; ld_last = 1'b0;
        check_state("load_after_run");
        rd1("full_rd_first", 32'h0);
        rd2("full_rd_last", 32'(4 * (DEPTH - 1)));
        for (int n = 0; n < 16; n++) rd1("full_rd_rand", 32'(4 * $urandom_range(0, DEPTH - 1)));

        // Asynchronous reset mid-load, then reload a single word
        do_reset("rst6");
        load_word($urandom, 1'b0);
        load_word($urandom, 1'b0);
        check_state("midload2");
        do_reset("midload_rst");
        load_word(32'h13579BDF, 1'b1);
        check_state("reload1");
        rd1("reload_rd", 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
